// File: rtl/osd_vram_arb_pkg.sv
// Shared OSD bus address bytes and the video RAM arbiter state encoding.
package osd_vram_arb_pkg;

    localparam logic [7:0] OSD_ADDR_BTN  = 8'hFB;
    localparam logic [7:0] OSD_ADDR_IRQ  = 8'hFC;
    localparam logic [7:0] OSD_ADDR_VRAM = 8'hFD;
    localparam logic [7:0] OSD_ADDR_CTRL = 8'hFE;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISP,
        ST_BUSW,
        ST_BUSR
    } arb_state_t;

endpackage

// File: rtl/osd_vram_sp.sv
// Single-port byte-wide video RAM, synchronous read with one cycle of latency.
module osd_vram_sp
    import osd_vram_arb_pkg::*;
#(
    parameter int c_ram_bits = 11
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [c_ram_bits-1:0] addr,
    input  logic [7:0]            wdata,
    output logic [7:0]            rdata
);

    logic [7:0] mem [0:(1 << c_ram_bits)-1];

    // Read-first; no reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/osd_vram_arb.sv
// Arbitrates the OSD video RAM between the display fetcher and the SPI bus,
// and holds the OSD control register.
module osd_vram_arb
    import osd_vram_arb_pkg::*;
#(
    parameter logic [7:0] c_addr_osd  = OSD_ADDR_VRAM,
    parameter logic [7:0] c_addr_ctrl = OSD_ADDR_CTRL,
    parameter int         c_ram_bits  = 11,
    parameter int         c_addr_bits = 32,
    parameter int         c_starve    = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rd,
    input  logic                   wr,
    input  logic [c_addr_bits-1:0] addr,
    input  logic [7:0]             wr_data,
    output logic [7:0]             rd_data,
    input  logic                   disp_req,
    input  logic [c_ram_bits-1:0]  disp_addr,
    output logic [7:0]             disp_data,
    output logic                   disp_valid,
    output logic                   osd_en
);

    localparam int CNT_W = $clog2(c_starve + 2);

    arb_state_t state, state_nxt;

    logic                  rd_q, wr_q;
    logic                  rd_edge, wr_edge;
    logic [7:0]            addr_hi;
    logic                  sel_ram, sel_ctrl;
    logic                  wpend, rpend;
    logic [c_ram_bits-1:0] waddr, raddr;
    logic [7:0]            wdata;
    logic [CNT_W-1:0]      cnt;
    logic                  bus_pend, starved, disp_ok;
    logic                  gnt_w, gnt_r;
    logic                  ram_en, ram_we;
    logic [c_ram_bits-1:0] ram_addr;
    logic [7:0]            ram_q;
    logic                  unused_addr;

    assign rd_edge     = rd & ~rd_q;
    assign wr_edge     = wr & ~wr_q;
    assign addr_hi     = addr[c_addr_bits-1 -: 8];
    assign sel_ram     = (addr_hi == c_addr_osd);
    assign sel_ctrl    = (addr_hi == c_addr_ctrl);
    assign unused_addr = ^addr[c_addr_bits-9:c_ram_bits];

    assign bus_pend = wpend | rpend;
    assign starved  = (cnt == CNT_W'(c_starve));
    // The request is still high on the disp_valid cycle, so it must not be re-granted then.
    assign disp_ok  = disp_req & ~disp_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            rd_q  <= rd;
            wr_q  <= wr;
        end
    end

    // A fresh edge beats a same-cycle grant, so the newer request stays pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wpend <= 1'b0;
            rpend <= 1'b0;
            waddr <= '0;
            raddr <= '0;
            wdata <= '0;
        end else begin
            if (wr_edge && sel_ram) begin
                wpend <= 1'b1;
                waddr <= addr[c_ram_bits-1:0];
                wdata <= wr_data;
            end else if (gnt_w) begin
                wpend <= 1'b0;
            end
            if (rd_edge && sel_ram) begin
                rpend <= 1'b1;
                raddr <= addr[c_ram_bits-1:0];
            end else if (gnt_r) begin
                rpend <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (gnt_w || gnt_r) begin
            cnt <= '0;
        end else if (bus_pend && !starved) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = ST_IDLE;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = disp_addr;
        gnt_w     = 1'b0;
        gnt_r     = 1'b0;
        if (state == ST_IDLE) begin
            if (bus_pend && (starved || !disp_ok)) begin
                ram_en = 1'b1;
                if (wpend) begin
                    gnt_w     = 1'b1;
                    ram_we    = 1'b1;
                    ram_addr  = waddr;
                    state_nxt = ST_BUSW;
                end else begin
                    gnt_r     = 1'b1;
                    ram_addr  = raddr;
                    state_nxt = ST_BUSR;
                end
            end else if (disp_ok) begin
                ram_en    = 1'b1;
                state_nxt = ST_DISP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            disp_valid <= 1'b0;
            disp_data  <= '0;
            rd_data    <= '0;
            osd_en     <= 1'b0;
        end else begin
            disp_valid <= (state == ST_DISP);
            if (state == ST_DISP) disp_data <= ram_q;
            if (wr_edge && sel_ctrl) osd_en <= wr_data[0];
            if (rd_edge && sel_ctrl) begin
                rd_data <= {7'b0, osd_en};
            end else if (state == ST_BUSR) begin
                rd_data <= ram_q;
            end
        end
    end

    osd_vram_sp #(.c_ram_bits(c_ram_bits)) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata),
        .rdata (ram_q)
    );

endmodule

// File: tb/tb_osd_vram_arb.sv
// Randomized self-checking bench for osd_vram_arb against a memory/register model.
module tb_osd_vram_arb;

    localparam int STARVE = 4;
    localparam int WIN    = STARVE + 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        rd, wr;
    logic [31:0] addr;
    logic [7:0]  wr_data, rd_data;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic [7:0]  disp_data;
    logic        disp_valid, osd_en;

    int checks = 0;
    int errors = 0;

    logic [7:0]  mem_m [0:2047];
    logic        osd_m;
    logic [7:0]  rd_m;
    logic [10:0] woffs [$];

    always #5 clk = ~clk;

    osd_vram_arb #(.c_starve(STARVE)) dut (
        .clk        (clk),
        .reset      (reset),
        .rd         (rd),
        .wr         (wr),
        .addr       (addr),
        .wr_data    (wr_data),
        .rd_data    (rd_data),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_data  (disp_data),
        .disp_valid (disp_valid),
        .osd_en     (osd_en)
    );

    task automatic bus_write(input logic [31:0] a, input logic [7:0] d);
        int w;
        w = $urandom_range(1, 2);
        @(negedge clk);
        addr = a; wr_data = d; wr = 1'b1;
        repeat (w) @(negedge clk);
        wr = 1'b0;
        repeat (STARVE + 3) @(negedge clk);
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [7:0] got);
        int w;
        w = $urandom_range(1, 2);
        @(negedge clk);
        addr = a; rd = 1'b1;
        repeat (w) @(negedge clk);
        rd = 1'b0;
        repeat (WIN - w) @(negedge clk);
        got = rd_data;
    endtask

    task automatic test_reset;
        reset = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; wr_data = '0;
        disp_req = 1'b0; disp_addr = '0;
        repeat (3) @(negedge clk);
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", rd_data); end
        checks++; if (disp_data !== 8'h00) begin errors++; $display("FAIL reset_disp_data: got %h expected 00", disp_data); end
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL reset_disp_valid: got %b expected 0", disp_valid); end
        checks++; if (osd_en !== 1'b0) begin errors++; $display("FAIL reset_osd_en: got %b expected 0", osd_en); end
        reset = 1'b0;
        osd_m = 1'b0; rd_m = 8'h00;
        @(negedge clk);
    endtask

    task automatic test_write_read;
        bit seen;
        bus_write(32'hFD000010, 8'h41);
        mem_m[16] = 8'h41;
        @(negedge clk);
        addr = 32'hFD000010; rd = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd = 1'b0;
            if (rd_data === 8'h41) seen = 1'b1;
        end
        checks++; if (!seen) begin errors++; $display("FAIL write_read_5cyc: got %h expected 41", rd_data); end
        rd_m = 8'h41;
    endtask

    task automatic test_ctrl;
        @(negedge clk);
        addr = 32'hFE000000; wr_data = 8'h01; wr = 1'b1;
        @(negedge clk);
        checks++; if (osd_en !== 1'b1) begin errors++; $display("FAIL ctrl_write_next: got %b expected 1", osd_en); end
        wr = 1'b0; osd_m = 1'b1;
        @(negedge clk);
        rd = 1'b1;
        @(negedge clk);
        checks++; if (rd_data !== 8'h01) begin errors++; $display("FAIL ctrl_read_next: got %h expected 01", rd_data); end
        rd = 1'b0; rd_m = 8'h01;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_coincident;
        @(negedge clk);
        addr = 32'hFD000005; wr_data = 8'h7E; wr = 1'b1; rd = 1'b1;
        @(negedge clk);
        wr = 1'b0; rd = 1'b0;
        repeat (WIN) @(negedge clk);
        mem_m[5] = 8'h7E; rd_m = 8'h7E;
        checks++; if (rd_data !== 8'h7E) begin errors++; $display("FAIL coincident_rw: got %h expected 7e", rd_data); end
    endtask

    task automatic test_out_of_window;
        logic [7:0] got;
        bus_write(32'hFD000000, 8'h33); mem_m[0] = 8'h33;
        bus_write(32'hFE000000, 8'h00); osd_m = 1'b0;
        checks++; if (osd_en !== 1'b0) begin errors++; $display("FAIL ctrl_clear: got %b expected 0", osd_en); end
        bus_write(32'h12000000, 8'hFF);
        checks++; if (osd_en !== 1'b0) begin errors++; $display("FAIL oow_write_osd_en: got %b expected 0", osd_en); end
        bus_read(32'hFD000000, got);
        checks++; if (got !== 8'h33) begin errors++; $display("FAIL oow_write_ram: got %h expected 33", got); end
        bus_read(32'h12000000, got);
        checks++; if (got !== 8'h33) begin errors++; $display("FAIL oow_read_hold: got %h expected 33", got); end
        rd_m = 8'h33;
    endtask

    task automatic test_display;
        int n;
        bus_write(32'hFD000123, 8'h5C); mem_m[11'h123] = 8'h5C;
        @(negedge clk);
        disp_addr = 11'h123; disp_req = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!disp_valid && n < 10);
        checks++; if (n != 2) begin errors++; $display("FAIL disp_latency: got %0d cycles expected 2", n); end
        checks++; if (disp_data !== 8'h5C) begin errors++; $display("FAIL disp_data: got %h expected 5c", disp_data); end
        disp_req = 1'b0;
        @(negedge clk);
        checks++; if (disp_valid !== 1'b0) begin errors++; $display("FAIL disp_pulse: got %b expected 0", disp_valid); end
        checks++; if (disp_data !== 8'h5C) begin errors++; $display("FAIL disp_hold: got %h expected 5c", disp_data); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_contention;
        int nvalid;
        bus_write(32'hFD000010, 8'hC3); mem_m[11'h010] = 8'hC3;
        bus_write(32'hFD000020, 8'h11); mem_m[11'h020] = 8'h11;
        @(negedge clk);
        disp_addr = 11'h010; disp_req = 1'b1;
        nvalid = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (cyc == 2) begin addr = 32'hFD000020; wr_data = 8'h9A; wr = 1'b1; end
            if (cyc == 3) wr = 1'b0;
            if (cyc == 8) begin addr = 32'hFD000020; rd = 1'b1; end
            if (cyc == 9) rd = 1'b0;
            @(negedge clk);
            if (disp_valid) begin
                nvalid++;
                checks++; if (disp_data !== 8'hC3) begin errors++; $display("FAIL contention_disp_data: got %h expected c3", disp_data); end
            end
            if (cyc == 8 + WIN) begin
                checks++; if (rd_data !== 8'h9A) begin errors++; $display("FAIL contention_bus_rw: got %h expected 9a", rd_data); end
            end
        end
        checks++; if (nvalid < 6) begin errors++; $display("FAIL contention_disp_count: got %0d expected >=6", nvalid); end
        disp_req = 1'b0;
        mem_m[11'h020] = 8'h9A; rd_m = 8'h9A;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_random;
        bit done;
        logic [7:0] got, d;
        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom) | 8'h01;
            bus_write({8'hFD, 13'h0, 11'h700 + 11'(i)}, d);
            mem_m[11'h700 + 11'(i)] = d;
        end
        done = 1'b0;
        fork
            begin
                logic [10:0] off;
                logic [7:0]  dv, gv, hi;
                int          kind;
                for (int i = 0; i < 40; i++) begin
                    kind = (woffs.size() == 0) ? 0 : int'($urandom_range(0, 4));
                    case (kind)
                        0: begin
                            off = 11'($urandom_range(0, 11'h6FF)); dv = 8'($urandom);
                            bus_write({8'hFD, 13'h0, off}, dv);
                            mem_m[off] = dv; woffs.push_back(off);
                        end
                        1: begin
                            off = woffs[$urandom_range(0, woffs.size() - 1)];
                            bus_read({8'hFD, 13'h0, off}, gv);
                            checks++; if (gv !== mem_m[off]) begin errors++; $display("FAIL rand_ram_read @%h: got %h expected %h", off, gv, mem_m[off]); end
                            rd_m = mem_m[off];
                        end
                        2: begin
                            dv = 8'($urandom);
                            bus_write(32'hFE000000, dv); osd_m = dv[0];
                            checks++; if (osd_en !== osd_m) begin errors++; $display("FAIL rand_ctrl_write: got %b expected %b", osd_en, osd_m); end
                        end
                        3: begin
                            bus_read(32'hFE000000, gv);
                            checks++; if (gv !== {7'b0, osd_m}) begin errors++; $display("FAIL rand_ctrl_read: got %h expected %h", gv, {7'b0, osd_m}); end
                            rd_m = {7'b0, osd_m};
                        end
                        default: begin
                            do hi = 8'($urandom); while (hi == 8'hFD || hi == 8'hFE);
                            if ($urandom_range(0, 1) == 1) begin
                                bus_write({hi, 24'($urandom)}, 8'($urandom));
                                checks++; if (osd_en !== osd_m) begin errors++; $display("FAIL rand_oow_write: got %b expected %b", osd_en, osd_m); end
                            end else begin
                                bus_read({hi, 24'($urandom)}, gv);
                                checks++; if (gv !== rd_m) begin errors++; $display("FAIL rand_oow_read: got %h expected %h", gv, rd_m); end
                            end
                        end
                    endcase
                end
                done = 1'b1;
            end
            begin
                logic [10:0] da;
                int          n;
                while (!done) begin
                    da = 11'h700 + 11'($urandom_range(0, 15));
                    disp_addr = da; disp_req = 1'b1;
                    n = 0;
                    do begin @(negedge clk); n++; end while (!disp_valid && n < 12);
                    checks++;
                    if (!disp_valid) begin
                        errors++; $display("FAIL rand_disp_timeout @%h: got no disp_valid expected one within 12", da);
                    end else if (disp_data !== mem_m[da]) begin
                        errors++; $display("FAIL rand_disp_data @%h: got %h expected %h", da, disp_data, mem_m[da]);
                    end
                    disp_req = 1'b0;
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                end
            end
        join
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset_mid;
        bus_write(32'hFD000055, 8'hA5); mem_m[11'h055] = 8'hA5;
        bus_write(32'hFE000000, 8'h01); osd_m = 1'b1;
        @(negedge clk);
        addr = 32'hFD000055; rd = 1'b1;
        repeat (2) @(negedge clk);
        // Read was granted one cycle ago, so the arbiter is in its bus-read cycle now.
        reset = 1'b1; rd = 1'b0;
        #1;
        checks++; if (rd_data !== 8'h00) begin errors++; $display("FAIL midreset_rd_data: got %h expected 00", rd_data); end
        checks++; if (disp_data !== 8'h00) begin errors++; $display("FAIL midreset_disp_data: got %h expected 00", disp_data); end
        checks++; if (osd_en !== 1'b0) begin errors++; $display("FAIL midreset_osd_en: got %b expected 0", osd_en); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            checks++;
            if (rd_data !== 8'h00 || disp_valid !== 1'b0) begin
                errors++; $display("FAIL midreset_quiet: got rd_data=%h disp_valid=%b expected 00/0", rd_data, disp_valid);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_write_read();
        test_ctrl();
        test_coincident();
        test_out_of_window();
        test_display();
        test_contention();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
